// File: rtl/job_request_packer.sv
// job_request_packer: packs 16-beat 32-bit AXI-Stream packets into one 496-bit
// job descriptor for the CCRF wrapper's incoming_job_requests stream. Packets of
// the wrong length are dropped, counted, and flagged with a sticky error bit.
module job_request_packer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned JOB_W  = 496,
    parameter int unsigned BEATS  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [WORD_W-1:0] s_axis_TDATA,
    input  logic              s_axis_TVALID,
    output logic              s_axis_TREADY,
    input  logic              s_axis_TLAST,
    output logic [JOB_W-1:0]  incoming_job_requests_V_TDATA,
    output logic              incoming_job_requests_V_TVALID,
    input  logic              incoming_job_requests_V_TREADY,
    output logic [CNT_W-1:0]  jobs_forwarded,
    output logic [CNT_W-1:0]  packets_dropped,
    output logic              framing_error
);

    localparam int unsigned IDX_W = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        StCollect,
        StDrain,
        StEmit
    } state_e;

    state_e             st_q, st_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [JOB_W-1:0]   tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tready_q, tready_d;
    logic [CNT_W-1:0]   jobs_q, jobs_d;
    logic [CNT_W-1:0]   drops_q, drops_d;
    logic               ferr_q, ferr_d;

    logic beat_fire;
    logic job_fire;

    assign beat_fire = s_axis_TVALID & tready_q;
    assign job_fire  = tvalid_q & incoming_job_requests_V_TREADY;

    // Next-state: beat assembly, length checking, and descriptor handoff.
    always_comb begin
        st_d     = st_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        jobs_d   = jobs_q;
        drops_d  = drops_q;
        ferr_d   = ferr_q;

        unique case (st_q)
            StCollect: begin
                if (beat_fire) begin
                    // Last beat only fills the 16 bits left above bit 479; its upper half
                    // falls outside the descriptor and is ignored.
                    for (int unsigned b = 0; b < JOB_W; b++) begin
                        if ((b / WORD_W) == 32'(idx_q)) begin
                            tdata_d[b] = s_axis_TDATA[b % WORD_W];
                        end
                    end
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (s_axis_TLAST) begin
                            st_d     = StEmit;
                            tvalid_d = 1'b1;
                        end else begin
                            st_d    = StDrain;
                            drops_d = drops_q + CNT_W'(1);
                            ferr_d  = 1'b1;
                        end
                    end else if (s_axis_TLAST) begin
                        idx_d   = '0;
                        drops_d = drops_q + CNT_W'(1);
                        ferr_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Overlong packet already counted; swallow the tail silently.
                if (beat_fire && s_axis_TLAST) begin
                    st_d  = StCollect;
                    idx_d = '0;
                end
            end
            StEmit: begin
                if (job_fire) begin
                    st_d     = StCollect;
                    tvalid_d = 1'b0;
                    idx_d    = '0;
                    jobs_d   = jobs_q + CNT_W'(1);
                end
            end
            default: begin
                st_d = StCollect;
            end
        endcase

        // Registered ready tracks the state being entered, so no input-to-output path.
        tready_d = (st_d != StEmit);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!areset) begin
            st_q     <= StCollect;
            idx_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tready_q <= 1'b0;
            jobs_q   <= '0;
            drops_q  <= '0;
            ferr_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tready_q <= tready_d;
            jobs_q   <= jobs_d;
            drops_q  <= drops_d;
            ferr_q   <= ferr_d;
        end
    end

    assign s_axis_TREADY                  = tready_q;
    assign incoming_job_requests_V_TDATA  = tdata_q;
    assign incoming_job_requests_V_TVALID = tvalid_q;
    assign jobs_forwarded                 = jobs_q;
    assign packets_dropped                = drops_q;
    assign framing_error                  = ferr_q;

endmodule

// File: tb/tb_job_request_packer.sv
// Directed bench for job_request_packer: normal packing, backpressure, short and
// long packets, mid-packet reset, and counter wrap with throughput.
module tb_job_request_packer;

    logic          aclk;
    logic          areset;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [495:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [15:0]   jobs;
    logic [15:0]   drops;
    logic          ferr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    job_request_packer dut (
        .aclk                           (aclk),
        .areset                         (areset),
        .s_axis_TDATA                   (s_data),
        .s_axis_TVALID                  (s_valid),
        .s_axis_TREADY                  (s_ready),
        .s_axis_TLAST                   (s_last),
        .incoming_job_requests_V_TDATA  (m_data),
        .incoming_job_requests_V_TVALID (m_valid),
        .incoming_job_requests_V_TREADY (m_ready),
        .jobs_forwarded                 (jobs),
        .packets_dropped                (drops),
        .framing_error                  (ferr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Free-running cycle count for throughput measurement.
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [495:0] obs, input logic [495:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected descriptor for a packet whose word k is base+k.
    function automatic logic [495:0] pack(input logic [31:0] base);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = base + 32'(k);
        return w[495:0];
    endfunction

    // Called at a negedge; returns at the negedge following the beat's transfer.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) check("beat_timeout", 496'(n), 496'(0));
        @(negedge aclk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] base, input int n, input int last_at);
        for (int k = 0; k < n; k++) send_beat(base + 32'(k), (k == last_at));
    endtask

    task automatic do_reset();
        areset = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
    endtask

    initial begin
        int t0;
        int t1;
        areset  = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);

        // Reset values, sampled while reset is held.
        check("rst_tready", 496'(s_ready), 496'(0));
        check("rst_tvalid", 496'(m_valid), 496'(0));
        check("rst_tdata", m_data, 496'(0));
        check("rst_jobs", 496'(jobs), 496'(0));
        check("rst_drops", 496'(drops), 496'(0));
        check("rst_ferr", 496'(ferr), 496'(0));
        areset = 1'b1;
        @(negedge aclk);
        check("post_rst_tready", 496'(s_ready), 496'(1));

        // Normal packet, downstream always ready.
        for (int k = 0; k < 16; k++) begin
            check("t1_tready_collect", 496'(s_ready), 496'(1));
            check("t1_tvalid_low", 496'(m_valid), 496'(0));
            send_beat(32'h1000_0000 + 32'(k), (k == 15));
        end
        check("t1_tvalid_latency", 496'(m_valid), 496'(1));
        check("t1_tready_emit", 496'(s_ready), 496'(0));
        check("t1_word0", 496'(m_data[31:0]), 496'(32'h1000_0000));
        check("t1_word14", 496'(m_data[479:448]), 496'(32'h1000_000E));
        check("t1_word15", 496'(m_data[495:480]), 496'(16'h000F));
        check("t1_jobs_before", 496'(jobs), 496'(0));
        @(negedge aclk);
        check("t1_tvalid_after", 496'(m_valid), 496'(0));
        check("t1_tready_after", 496'(s_ready), 496'(1));
        check("t1_jobs", 496'(jobs), 496'(1));

        // Backpressure: descriptor 99 held for 20 cycles.
        do_reset();
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) send_beat((k == 0) ? 32'd99 : 32'd0, (k == 15));
        for (int i = 0; i < 20; i++) begin
            check("t2_tvalid_hold", 496'(m_valid), 496'(1));
            check("t2_tdata_hold", m_data, 496'd99);
            check("t2_tready_hold", 496'(s_ready), 496'(0));
            @(negedge aclk);
        end
        check("t2_jobs_held", 496'(jobs), 496'(0));
        m_ready = 1'b1;
        @(negedge aclk);
        check("t2_tvalid_done", 496'(m_valid), 496'(0));
        check("t2_jobs", 496'(jobs), 496'(1));

        // Short packet followed by a good one.
        do_reset();
        send_pkt(32'hDEAD_0000, 5, 4);
        check("t3_drops_short", 496'(drops), 496'(1));
        check("t3_ferr_short", 496'(ferr), 496'(1));
        check("t3_tvalid_short", 496'(m_valid), 496'(0));
        send_pkt(32'h2000_0000, 16, 15);
        check("t3_tvalid", 496'(m_valid), 496'(1));
        check("t3_tdata", m_data, pack(32'h2000_0000));
        @(negedge aclk);
        check("t3_jobs", 496'(jobs), 496'(1));
        check("t3_drops", 496'(drops), 496'(1));

        // Long packet drained, then a good one.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k >= 16) check("t4_tready_drain", 496'(s_ready), 496'(1));
            send_beat(32'h6000_0000 + 32'(k), (k == 19));
            check("t4_no_tvalid", 496'(m_valid), 496'(0));
            if (k == 15) check("t4_drops_at15", 496'(drops), 496'(1));
        end
        check("t4_drops", 496'(drops), 496'(1));
        check("t4_ferr", 496'(ferr), 496'(1));
        check("t4_jobs_none", 496'(jobs), 496'(0));
        send_pkt(32'h3000_0000, 16, 15);
        check("t4_tdata", m_data, pack(32'h3000_0000));
        @(negedge aclk);
        check("t4_jobs", 496'(jobs), 496'(1));
        check("t4_drops_after", 496'(drops), 496'(1));

        // Reset mid-packet with ferr and counters nonzero.
        send_pkt(32'h4444_0000, 8, -1);
        areset = 1'b0;
        @(negedge aclk);
        check("t5_tready", 496'(s_ready), 496'(0));
        check("t5_tvalid", 496'(m_valid), 496'(0));
        check("t5_tdata", m_data, 496'(0));
        check("t5_jobs_rst", 496'(jobs), 496'(0));
        check("t5_drops_rst", 496'(drops), 496'(0));
        check("t5_ferr_rst", 496'(ferr), 496'(0));
        areset = 1'b1;
        @(negedge aclk);
        send_pkt(32'h5000_0000, 16, 15);
        check("t5_new_tdata", m_data, pack(32'h5000_0000));
        @(negedge aclk);
        check("t5_jobs", 496'(jobs), 496'(1));
        check("t5_drops", 496'(drops), 496'(0));
        check("t5_ferr", 496'(ferr), 496'(0));

        // Counter wrap and back-to-back throughput.
        force dut.jobs_q = 16'hFFFE;
        @(negedge aclk);
        release dut.jobs_q;
        @(negedge aclk);
        check("t6_jobs_forced", 496'(jobs), 496'(16'hFFFE));
        send_pkt(32'h7000_0000, 16, 15);
        t0 = cyc;
        check("t6_jobs_a", 496'(jobs), 496'(16'hFFFE));
        send_pkt(32'h7100_0000, 16, 15);
        t1 = cyc;
        check("t6_jobs_b", 496'(jobs), 496'(16'hFFFF));
        check("t6_period_a", 496'(t1 - t0), 496'(17));
        check("t6_tdata_b", m_data, pack(32'h7100_0000));
        send_pkt(32'h7200_0000, 16, 15);
        t0 = cyc;
        check("t6_jobs_c", 496'(jobs), 496'(16'h0000));
        check("t6_period_b", 496'(t0 - t1), 496'(17));
        @(negedge aclk);
        check("t6_jobs_d", 496'(jobs), 496'(16'h0001));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
